cpu_register_file_write_arbiter: RTL and testbench

Shares the single write port of the CPU register file between several writeback sources (ALU, load unit, tensor-core result path). Each cycle the block grants at most one requester by round-robin and registers the winning address and data onto the register-file write port. A requester may lock the port for a multi-cycle burst. Writes to register 0 are consumed and counted but never forwarded.

---
 rtl/cpu_register_file_write_arbiter_if.sv | 35 +++
 rtl/cpu_register_file_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_cpu_register_file_write_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_register_file_write_arbiter_if.sv
// Write-port bus between the writeback sources and the register-file write arbiter.
// The arbiter connects through the slave modport; requesters and observers use master.
interface cpu_register_file_write_arbiter_if #(
    parameter int NUMBER_OF_REQUESTERS = 3,
    parameter int NUMBER_OF_REGISTERS  = 8,
    parameter int DATA_WIDTH           = 8
);
    localparam int N  = NUMBER_OF_REQUESTERS;
    localparam int AW = $clog2(NUMBER_OF_REGISTERS);
    localparam int GW = $clog2(NUMBER_OF_REQUESTERS);

    logic [N-1:0]            req_valid_in;
    logic [N-1:0]            req_lock_in;
    logic [N*AW-1:0]         req_address_in;
    logic [N*DATA_WIDTH-1:0] req_data_in;
    logic [N-1:0]            req_ready_out;
    logic                    write_enable_out;
    logic [AW-1:0]           write_register_address_out;
    logic [DATA_WIDTH-1:0]   write_data_out;
    logic [GW-1:0]           grant_id_out;
    logic                    locked_out;
    logic [7:0]              dropped_write_count_out;

    modport master (
        output req_valid_in, req_lock_in, req_address_in, req_data_in,
        input  req_ready_out, write_enable_out, write_register_address_out,
        input  write_data_out, grant_id_out, locked_out, dropped_write_count_out
    );

    modport slave (
        input  req_valid_in, req_lock_in, req_address_in, req_data_in,
        output req_ready_out, write_enable_out, write_register_address_out,
        output write_data_out, grant_id_out, locked_out, dropped_write_count_out
    );
endinterface

// File: rtl/cpu_register_file_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with per-requester
// burst locking and silent consumption (with a saturating count) of writes to r0.
module cpu_register_file_write_arbiter #(
    parameter int NUMBER_OF_REQUESTERS = 3,
    parameter int NUMBER_OF_REGISTERS  = 8,
    parameter int DATA_WIDTH           = 8
) (
    input  logic                                clock_in,
    input  logic                                reset_n_in,
    cpu_register_file_write_arbiter_if.slave    bus
);
    localparam int N  = NUMBER_OF_REQUESTERS;
    localparam int AW = $clog2(NUMBER_OF_REGISTERS);
    localparam int GW = $clog2(NUMBER_OF_REQUESTERS);

    localparam logic [0:0] ST_ARBITRATE = 1'b0;
    localparam logic [0:0] ST_LOCKED    = 1'b1;

    logic [0:0]            r_state;
    logic [GW-1:0]         r_owner;
    logic [GW-1:0]         r_rr_pointer;
    logic                  r_write_enable;
    logic [AW-1:0]         r_write_address;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic [GW-1:0]         r_grant_id;
    logic [7:0]            r_dropped_count;

    logic                  w_pick_found;
    logic [GW-1:0]         w_pick_id;
    int                    w_scan_idx;
    logic [N-1:0]          w_ready;
    logic [GW-1:0]         w_grant_id;
    logic                  w_handshake;
    logic                  w_handshake_lock;
    logic [AW-1:0]         w_handshake_address;
    logic [DATA_WIDTH-1:0] w_handshake_data;

    function automatic logic [GW-1:0] next_index(input logic [GW-1:0] idx);
        if (idx == GW'(N - 1)) begin
            next_index = {GW{1'b0}};
        end else begin
            next_index = idx + GW'(1);
        end
    endfunction

    // Round-robin scan: first valid requester at or after the pointer, wrapping modulo N.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = {GW{1'b0}};
        w_scan_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_scan_idx = int'(r_rr_pointer) + k;
            if (w_scan_idx >= N) begin
                w_scan_idx = w_scan_idx - N;
            end else begin
                w_scan_idx = w_scan_idx;
            end
            if (!w_pick_found && bus.req_valid_in[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_id    = GW'(w_scan_idx);
            end else begin
                w_pick_found = w_pick_found;
            end
        end
    end

    // Ready generation: nobody during reset, only the owner while locked.
    always_comb begin
        w_ready    = {N{1'b0}};
        w_grant_id = {GW{1'b0}};
        if (!reset_n_in) begin
            w_ready    = {N{1'b0}};
            w_grant_id = {GW{1'b0}};
        end else if (r_state == ST_LOCKED) begin
            w_grant_id          = r_owner;
            w_ready[r_owner]    = bus.req_valid_in[r_owner];
        end else begin
            w_grant_id          = w_pick_id;
            w_ready[w_pick_id]  = w_pick_found;
        end
    end

    assign w_handshake         = |(bus.req_valid_in & w_ready);
    assign w_handshake_lock    = bus.req_lock_in[w_grant_id];
    assign w_handshake_address = bus.req_address_in[int'(w_grant_id) * AW +: AW];
    assign w_handshake_data    = bus.req_data_in[int'(w_grant_id) * DATA_WIDTH +: DATA_WIDTH];

    // Arbitration state, lock owner and round-robin pointer.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_state      <= ST_ARBITRATE;
            r_owner      <= {GW{1'b0}};
            r_rr_pointer <= {GW{1'b0}};
        end else begin
            case (r_state)
                ST_ARBITRATE: begin
                    if (w_handshake && w_handshake_lock) begin
                        r_state <= ST_LOCKED;
                        r_owner <= w_grant_id;
                    end else if (w_handshake) begin
                        r_rr_pointer <= next_index(w_grant_id);
                    end else begin
                        r_rr_pointer <= r_rr_pointer;
                    end
                end
                ST_LOCKED: begin
                    // Leaving on an unlocking write or when the owner stops requesting.
                    if (!(w_handshake && w_handshake_lock)) begin
                        r_state      <= ST_ARBITRATE;
                        r_rr_pointer <= next_index(r_owner);
                    end else begin
                        r_state <= ST_LOCKED;
                    end
                end
                default: begin
                    r_state <= ST_ARBITRATE;
                end
            endcase
        end
    end

    // Write-port staging; writes to r0 update the grant but only bump the drop counter.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_write_enable  <= 1'b0;
            r_write_address <= {AW{1'b0}};
            r_write_data    <= {DATA_WIDTH{1'b0}};
            r_grant_id      <= {GW{1'b0}};
            r_dropped_count <= 8'd0;
        end else if (w_handshake) begin
            r_write_address <= w_handshake_address;
            r_write_data    <= w_handshake_data;
            r_grant_id      <= w_grant_id;
            if (w_handshake_address == {AW{1'b0}}) begin
                r_write_enable <= 1'b0;
                if (r_dropped_count != 8'hFF) begin
                    r_dropped_count <= r_dropped_count + 8'd1;
                end else begin
                    r_dropped_count <= r_dropped_count;
                end
            end else begin
                r_write_enable <= 1'b1;
            end
        end else begin
            r_write_enable <= 1'b0;
        end
    end

    assign bus.req_ready_out              = w_ready;
    assign bus.write_enable_out           = r_write_enable;
    assign bus.write_register_address_out = r_write_address;
    assign bus.write_data_out             = r_write_data;
    assign bus.grant_id_out               = r_grant_id;
    assign bus.locked_out                 = (r_state == ST_LOCKED);
    assign bus.dropped_write_count_out    = r_dropped_count;
endmodule

// File: tb/tb_cpu_register_file_write_arbiter.sv
// Directed bench for the register-file write arbiter: round-robin, lock bursts,
// lock release on valid drop, r0 drop saturation, reset mid-burst, negative data.
module tb_cpu_register_file_write_arbiter;
    localparam int N  = 3;
    localparam int NR = 8;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cpu_register_file_write_arbiter_if #(
        .NUMBER_OF_REQUESTERS(N), .NUMBER_OF_REGISTERS(NR), .DATA_WIDTH(DW)
    ) bus ();

    cpu_register_file_write_arbiter #(
        .NUMBER_OF_REQUESTERS(N), .NUMBER_OF_REGISTERS(NR), .DATA_WIDTH(DW)
    ) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_address_in[i*AW +: AW] = a;
        bus.req_data_in[i*DW +: DW]    = d;
    endtask

    task automatic chk_write(input string tag, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [1:0] g);
        chk({tag, "_we"},   32'(bus.write_enable_out), 32'(we));
        chk({tag, "_addr"}, 32'(bus.write_register_address_out), 32'(a));
        chk({tag, "_data"}, 32'(bus.write_data_out), 32'(d));
        chk({tag, "_gnt"},  32'(bus.grant_id_out), 32'(g));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req_valid_in   = 3'b000;
        bus.req_lock_in    = 3'b000;
        bus.req_address_in = '0;
        bus.req_data_in    = '0;
        set_req(0, 3'd1, 8'd10);
        set_req(1, 3'd2, 8'd20);
        set_req(2, 3'd3, 8'd30);
        tick();
        tick();

        // Reset state, and no ready while in reset even with requests pending.
        chk_write("rst", 1'b0, 3'd0, 8'd0, 2'd0);
        chk("rst_locked", 32'(bus.locked_out), 32'd0);
        chk("rst_drop", 32'(bus.dropped_write_count_out), 32'd0);
        bus.req_valid_in = 3'b111;
        #1;
        chk("rst_ready", 32'(bus.req_ready_out), 32'b000);

        // Round-robin with all requesters valid.
        rst_n = 1'b1;
        #1;
        chk("rr_ready0", 32'(bus.req_ready_out), 32'b001);
        tick();
        chk_write("rr_w0", 1'b1, 3'd1, 8'd10, 2'd0);
        chk("rr_ready1", 32'(bus.req_ready_out), 32'b010);
        tick();
        chk_write("rr_w1", 1'b1, 3'd2, 8'd20, 2'd1);
        chk("rr_ready2", 32'(bus.req_ready_out), 32'b100);
        tick();
        chk_write("rr_w2", 1'b1, 3'd3, 8'd30, 2'd2);
        tick();
        chk_write("rr_w3", 1'b1, 3'd1, 8'd10, 2'd0);
        bus.req_valid_in = 3'b000;
        tick();
        chk_write("rr_idle", 1'b0, 3'd1, 8'd10, 2'd0);

        // Lock burst by requester 1 (pointer is 1 now) with 0 and 2 competing.
        bus.req_valid_in = 3'b111;
        bus.req_lock_in  = 3'b010;
        #1;
        chk("lk_ready0", 32'(bus.req_ready_out), 32'b010);
        tick();
        chk_write("lk_w1", 1'b1, 3'd2, 8'd20, 2'd1);
        chk("lk_locked1", 32'(bus.locked_out), 32'd1);
        chk("lk_ready1", 32'(bus.req_ready_out), 32'b010);
        set_req(1, 3'd4, 8'd21);
        tick();
        chk_write("lk_w2", 1'b1, 3'd4, 8'd21, 2'd1);
        chk("lk_locked2", 32'(bus.locked_out), 32'd1);
        set_req(1, 3'd5, 8'd22);
        tick();
        chk_write("lk_w3", 1'b1, 3'd5, 8'd22, 2'd1);
        bus.req_lock_in = 3'b000;
        set_req(1, 3'd6, 8'd23);
        tick();
        chk_write("lk_w4", 1'b1, 3'd6, 8'd23, 2'd1);
        chk("lk_unlocked", 32'(bus.locked_out), 32'd0);
        chk("lk_ready4", 32'(bus.req_ready_out), 32'b100);
        tick();
        chk_write("lk_w5", 1'b1, 3'd3, 8'd30, 2'd2);
        tick();
        chk_write("lk_w6", 1'b1, 3'd1, 8'd10, 2'd0);
        bus.req_valid_in = 3'b000;
        tick();

        // Requester 2 locks, then drops valid: back to arbitration with pointer 0.
        bus.req_valid_in = 3'b100;
        bus.req_lock_in  = 3'b100;
        tick();
        chk_write("vd_w0", 1'b1, 3'd3, 8'd30, 2'd2);
        chk("vd_locked", 32'(bus.locked_out), 32'd1);
        bus.req_valid_in = 3'b011;
        bus.req_lock_in  = 3'b000;
        #1;
        chk("vd_ready_locked", 32'(bus.req_ready_out), 32'b000);
        tick();
        chk("vd_we", 32'(bus.write_enable_out), 32'd0);
        chk("vd_unlocked", 32'(bus.locked_out), 32'd0);
        chk("vd_ready_arb", 32'(bus.req_ready_out), 32'b001);
        tick();
        chk_write("vd_w1", 1'b1, 3'd1, 8'd10, 2'd0);
        bus.req_valid_in = 3'b000;
        tick();

        // 300 accepted writes to r0: never forwarded, counter saturates at 255.
        set_req(0, 3'd0, 8'd55);
        bus.req_valid_in = 3'b001;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 1) begin
                chk("r0_we1", 32'(bus.write_enable_out), 32'd0);
                chk("r0_gnt1", 32'(bus.grant_id_out), 32'd0);
                chk("r0_cnt1", 32'(bus.dropped_write_count_out), 32'd1);
            end
            if (i == 254) chk("r0_cnt254", 32'(bus.dropped_write_count_out), 32'd254);
            if (i == 255) chk("r0_cnt255", 32'(bus.dropped_write_count_out), 32'd255);
        end
        chk("r0_we300", 32'(bus.write_enable_out), 32'd0);
        chk("r0_cnt300", 32'(bus.dropped_write_count_out), 32'd255);
        bus.req_valid_in = 3'b000;
        set_req(0, 3'd1, 8'd10);
        tick();

        // Reset while requester 1 holds a locked burst with a write staged.
        set_req(1, 3'd2, 8'd20);
        bus.req_valid_in = 3'b010;
        bus.req_lock_in  = 3'b010;
        tick();
        chk("rb_locked", 32'(bus.locked_out), 32'd1);
        tick();
        chk_write("rb_staged", 1'b1, 3'd2, 8'd20, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_ready_in_rst", 32'(bus.req_ready_out), 32'b000);
        tick();
        chk("rb_we", 32'(bus.write_enable_out), 32'd0);
        chk("rb_locked_clr", 32'(bus.locked_out), 32'd0);
        chk("rb_ready", 32'(bus.req_ready_out), 32'b000);
        bus.req_valid_in = 3'b011;
        bus.req_lock_in  = 3'b000;
        rst_n = 1'b1;
        #1;
        chk("rb_ready_post", 32'(bus.req_ready_out), 32'b001);
        tick();
        chk_write("rb_w0", 1'b1, 3'd1, 8'd10, 2'd0);
        bus.req_valid_in = 3'b000;
        tick();

        // Negative data to r7, then idle: enable drops, address/data hold.
        set_req(0, 3'd7, 8'h80);
        bus.req_valid_in = 3'b001;
        tick();
        chk_write("neg_w", 1'b1, 3'd7, 8'h80, 2'd0);
        bus.req_valid_in = 3'b000;
        tick();
        chk_write("neg_idle1", 1'b0, 3'd7, 8'h80, 2'd0);
        tick();
        chk_write("neg_idle2", 1'b0, 3'd7, 8'h80, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
